priv_1_12_csr_arbiter: RTL

//  Sequences and shares the single CSR port of the v1.12 privilege block between two requesters:

---
 rtl/priv_1_12_csr_arbiter_if.sv | 38 +++
 rtl/priv_1_12_csr_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/priv_1_12_csr_arbiter_if.sv
// Bus bundle between the two CSR requesters, the arbiter and the CSR file port.
// Module: priv_1_12_csr_arbiter_if    Rev 1.0
`default_nettype none

interface priv_1_12_csr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][11:0]     req_addr;
  logic [NREQ-1:0][1:0]      req_op;
  logic [NREQ-1:0][XLEN-1:0] req_wdata;
  logic [NREQ-1:0]           ack;
  logic [XLEN-1:0]           rdata;
  logic                      err;
  logic [11:0]               csr_addr;
  logic                      csr_mod;
  logic [XLEN-1:0]           new_csr_val;
  logic [XLEN-1:0]           old_csr_val;
  logic                      invalid_csr;

  // Environment view: requesters plus the CSR file
  modport master (
    output req, req_addr, req_op, req_wdata,
    input  ack, rdata, err,
    output old_csr_val, invalid_csr,
    input  csr_addr, csr_mod, new_csr_val
  );

  modport slave (
    input  req, req_addr, req_op, req_wdata,
    output ack, rdata, err,
    input  old_csr_val, invalid_csr,
    output csr_addr, csr_mod, new_csr_val
  );
endinterface

`default_nettype wire

// File: rtl/priv_1_12_csr_arbiter.sv
// Module: priv_1_12_csr_arbiter    Rev 1.0
// Round-robin arbiter running atomic read/modify/write CSR accesses; optional PRIV_CSR_ACCESS_CHECK_EN.
`default_nettype none

module priv_1_12_csr_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  input  wire logic [1:0] curr_priv_i,
  priv_1_12_csr_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  logic [1:0]      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            gnt_q, gnt_d;
  logic [11:0]     addr_q, addr_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] nv_q, nv_d;

  logic            gnt_sel;
  logic            need_wr;
  logic            fault;
  logic            priv_fault;
  logic            ro_fault;
  logic [XLEN-1:0] nv;

  // With both requesting, the one not served last wins
  assign gnt_sel = (&bus.req) ? ~last_grant_q : bus.req[1];

  assign need_wr = (op_q == OP_RW) || (op_q[1] && (wdata_q != '0));

  always_comb begin
    nv = bus.old_csr_val;
    case (op_q)
      OP_RW:   nv = wdata_q;
      OP_RS:   nv = bus.old_csr_val | wdata_q;
      OP_READ: nv = bus.old_csr_val;
      default: nv = bus.old_csr_val & ~wdata_q;
    endcase
  end

`ifdef PRIV_CSR_ACCESS_CHECK_EN
  assign priv_fault = (addr_q[9:8] > curr_priv_i);
  assign ro_fault   = need_wr && (addr_q[11:10] == 2'b11);
`else
  logic unused_priv;
  assign unused_priv = ^curr_priv_i;
  assign priv_fault  = 1'b0;
  assign ro_fault    = 1'b0;
`endif

  assign fault = bus.invalid_csr | priv_fault | ro_fault;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      op_q         <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      nv_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      nv_q         <= nv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    nv_d         = nv_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_d        = gnt_sel;
          last_grant_d = gnt_sel;
          addr_d       = bus.req_addr[gnt_sel];
          op_d         = bus.req_op[gnt_sel];
          wdata_d      = bus.req_wdata[gnt_sel];
          state_d      = S_RD;
        end
      end
      S_RD: begin
        rdata_d = bus.old_csr_val;
        err_d   = fault;
        nv_d    = nv;
        state_d = (need_wr && !fault) ? S_WR : S_RSP;
      end
      S_WR:    state_d = S_RSP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset kills csr_mod at once
  always_comb begin
    bus.csr_addr    = addr_q;
    bus.csr_mod     = (state_q == S_WR);
    bus.new_csr_val = (state_q == S_WR) ? nv_q : '0;
    bus.ack         = '0;
    bus.rdata       = '0;
    bus.err         = 1'b0;
    if (state_q == S_RSP) begin
      bus.ack[gnt_q] = 1'b1;
      bus.rdata      = rdata_q;
      bus.err        = err_q;
    end
  end

endmodule

`default_nettype wire
